// File: rtl/io_bus_pkg.sv
// Shared definitions for the I/O bus arbiter: bus widths, phase lengths and
// the bus-cycle state encoding.
package io_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    localparam int SETUP_CYC_DEF  = 1;
    localparam int STROBE_CYC_DEF = 2;
    localparam int HOLD_CYC_DEF   = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } bus_state_e;

    // Down-counter value loaded on phase entry so the phase lasts cyc cycles.
    function automatic logic [CNT_W-1:0] phase_load(input int cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the port that did not win last
// time is granted; a single requester always wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = req[1];
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the 8-bit parallel I/O bus between two requesters and sequences a
// SETUP / STROBE / HOLD read or write cycle for the granted one.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int SETUP_CYC  = SETUP_CYC_DEF,
    parameter int STROBE_CYC = STROBE_CYC_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              ior_,
    output logic              iow_,
    output logic              busy
);

    bus_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              last_grant_q, last_grant_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              ior_n_q, ior_n_d;
    logic              iow_n_q, iow_n_d;
    logic              drive_q, drive_d;
    logic              busy_q, busy_d;

    logic [1:0]        eligible;
    logic              gnt_valid;
    logic              gnt_id;

    // A port is masked while its done pulse is showing, so a requester that
    // has not yet dropped req cannot immediately receive a duplicate cycle.
    assign eligible = {req1 & ~done1_q, req0 & ~done0_q};

    rr_arbiter2 u_rr_arbiter2 (
        .req        (eligible),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ior_n_d      = 1'b1;
        iow_n_d      = 1'b1;
        drive_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    gnt_d        = gnt_id;
                    we_d         = gnt_id ? we1 : we0;
                    addr_d       = gnt_id ? addr1 : addr0;
                    wdata_d      = gnt_id ? wdata1 : wdata0;
                    last_grant_d = gnt_id;
                    drive_d      = gnt_id ? we1 : we0;
                    cnt_d        = phase_load(SETUP_CYC);
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                drive_d = we_q;
                if (cnt_q == '0) begin
                    cnt_d   = phase_load(STROBE_CYC);
                    ior_n_d = we_q;
                    iow_n_d = ~we_q;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STROBE: begin
                drive_d = we_q;
                if (cnt_q == '0) begin
                    // Read data is captured on the edge that ends the strobe.
                    if (!we_q) begin
                        if (gnt_q) begin
                            rdata1_d = data;
                        end else begin
                            rdata0_d = data;
                        end
                    end
                    cnt_d   = phase_load(HOLD_CYC);
                    state_d = HOLD;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    ior_n_d = we_q;
                    iow_n_d = ~we_q;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    done0_d = ~gnt_q;
                    done1_d = gnt_q;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    drive_d = we_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= 1'b1;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ior_n_q      <= 1'b1;
            iow_n_q      <= 1'b1;
            drive_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ior_n_q      <= ior_n_d;
            iow_n_q      <= iow_n_d;
            drive_q      <= drive_d;
            busy_q       <= busy_d;
        end
    end

    assign addr   = addr_q;
    assign data   = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign ior_   = ior_n_q;
    assign iow_   = iow_n_q;
    assign busy   = busy_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule
